// File: rtl/sakebi_arb_pkg.sv
// sakebi_arb_pkg: state encoding, state enum and width helper for the FIFO write arbiter
package sakebi_arb_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;
    typedef enum logic [1:0] {IDLE = ST_IDLE, HDR = ST_HDR, XFER = ST_XFER, DROP = ST_DROP} arb_state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sakebi_rr_pick.sv
// sakebi_rr_pick: combinational round-robin picker; ports req (requests), ptr (last winner), gnt_id (winner), any (some request)
module sakebi_rr_pick import sakebi_arb_pkg::*; #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]       req,
    input  logic [id_w(N_REQ)-1:0] ptr,
    output logic [id_w(N_REQ)-1:0] gnt_id,
    output logic                   any
);
    localparam int ID_W = id_w(N_REQ);
    assign any = |req;
    // Walk from farthest to nearest so the first requester after ptr wins.
    always_comb begin
        gnt_id = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[ID_W'((int'(ptr) + i) % N_REQ)]) gnt_id = ID_W'((int'(ptr) + i) % N_REQ);
        end
    end
endmodule

// File: rtl/sakebi_fifo_wr_arbiter.sv
// sakebi_fifo_wr_arbiter: packet-granular round-robin arbiter for one async FIFO write port
// Ports: i_clk/i_rst (sync, active-high); i_req_valid/i_req_data/i_req_last in, o_req_ready out (per source);
// i_wr_ready in, o_wr_en/o_wr_data out (FIFO write side); o_busy, o_grant_id, o_trunc status (registered).
// Optional SAKEBI_ARB_SRCID_EN: each packet is preceded by a header beat carrying the source index.
module sakebi_fifo_wr_arbiter import sakebi_arb_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]            i_req_last,
    output logic [N_REQ-1:0]            o_req_ready,
    input  logic                        i_wr_ready,
    output logic                        o_wr_en,
    output logic [DATA_WIDTH-1:0]       o_wr_data,
    output logic                        o_busy,
    output logic [id_w(N_REQ)-1:0]      o_grant_id,
    output logic                        o_trunc
);
    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS);
    logic [1:0] state;
    logic [ID_W-1:0] sel, ptr, pick;
    logic [CNT_W-1:0] cnt;
    logic any, in_hdr, ready_sel, acc, cur_last;
    logic [DATA_WIDTH-1:0] src_data [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_src
        assign src_data[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef SAKEBI_ARB_SRCID_EN
    localparam logic [1:0] ST_FIRST = ST_HDR;
    assign in_hdr = state == ST_HDR;
`else
    localparam logic [1:0] ST_FIRST = ST_XFER;
    assign in_hdr = 1'b0;
`endif
    sakebi_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (i_req_valid),
        .ptr    (ptr),
        .gnt_id (pick),
        .any    (any)
    );
    // XFER only takes a beat the FIFO can absorb; DROP swallows beats unconditionally.
    assign ready_sel   = (state == ST_XFER) ? i_wr_ready : (state == ST_DROP);
    assign o_req_ready = ready_sel ? N_REQ'(1) << sel : '0;
    assign acc         = ready_sel & i_req_valid[sel];
    assign cur_last    = i_req_last[sel];
    assign o_wr_en     = i_wr_ready & (in_hdr | ((state == ST_XFER) & i_req_valid[sel]));
    assign o_wr_data   = in_hdr ? DATA_WIDTH'(sel) : src_data[sel];
    assign o_busy      = state != ST_IDLE;
    assign o_grant_id  = sel;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            ptr     <= ID_W'(N_REQ - 1);
            sel     <= '0;
            cnt     <= '0;
            o_trunc <= 1'b0;
        end else begin
            o_trunc <= 1'b0;
            case (state)
                ST_IDLE: if (any) begin
                    sel   <= pick;
                    cnt   <= '0;
                    state <= ST_FIRST;
                end
`ifdef SAKEBI_ARB_SRCID_EN
                ST_HDR: if (i_wr_ready) state <= ST_XFER;
`endif
                ST_XFER: if (acc) begin
                    cnt <= cnt + 1'b1;
                    if (cur_last) begin
                        state <= ST_IDLE;
                        ptr   <= sel;
                    end else if (cnt == CNT_W'(MAX_BEATS - 1)) begin
                        o_trunc <= 1'b1;
                        state   <= ST_DROP;
                    end
                end
                ST_DROP: if (acc && cur_last) begin
                    state <= ST_IDLE;
                    ptr   <= sel;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sakebi_fifo_wr_arbiter.md
# sakebi_fifo_wr_arbiter

Round-robin, packet-granular arbiter that shares the single write port of a `sakebi_async_fifo` among `N_REQ` source streams in the write clock domain. Once a source is granted, the arbiter holds the grant until that source's packet ends, so packets are never interleaved in the FIFO. It enforces a maximum packet length and drops the excess beats of over-long packets. Optionally, it prefixes each packet with a source-ID header beat.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be ≥ 2.
- `DATA_WIDTH`, 8: beat width; must match the FIFO and be ≥ `$clog2(N_REQ)`.
- `MAX_BEATS`, 64: maximum payload beats forwarded per packet; must be ≥ 2.

Ports:
- `i_clk`, in, 1: the single clock; this is the FIFO write clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_req_valid`, in, N_REQ: per-source beat valid.
- `i_req_data`, in, N_REQ*DATA_WIDTH: per-source beat; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `i_req_last`, in, N_REQ: per-source end-of-packet flag; qualified by valid.
- `o_req_ready`, out, N_REQ: per-source beat accept.
- `i_wr_ready`, in, 1: connect to FIFO `o_wr_ready`.
- `o_wr_en`, out, 1: connect to FIFO `i_wr_en`.
- `o_wr_data`, out, DATA_WIDTH: connect to FIFO `i_wr_data`.
- `o_busy`, out, 1: high in any state other than IDLE.
- `o_grant_id`, out, $clog2(N_REQ): the current or most recent grantee.
- `o_trunc`, out, 1: one-cycle pulse when a packet is truncated.

## Operation
- The FSM has states IDLE, HDR, XFER and DROP.
- IDLE:
  - If any `i_req_valid` is high, pick the winner by round-robin. Search starts at `ptr+1` and wraps modulo `N_REQ`.
  - Register the winner into `sel` and `o_grant_id`.
  - Go to HDR when the header is enabled, otherwise go to XFER.
  - All readies are 0.
- HDR:
  - `o_wr_en = i_wr_ready`.
  - `o_wr_data = sel`, zero-extended to `DATA_WIDTH`.
  - When `i_wr_ready` is high, go to XFER.
- XFER:
  - `o_req_ready[sel] = i_wr_ready`; all other readies are 0.
  - `o_wr_en = i_req_valid[sel] & i_wr_ready`.
  - `o_wr_data = i_req_data[sel]`.
  - An accepted beat increments `cnt`. `cnt` is `$clog2(MAX_BEATS)` bits wide and is cleared on entry to XFER.
- Leaving XFER:
  - Accepted beat with `last`: go to IDLE and set `ptr <= sel`.
  - Else, accepted beat with `cnt == MAX_BEATS-1`: pulse `o_trunc`, go to DROP.
- DROP:
  - `o_req_ready[sel] = 1` and `o_wr_en = 0`; beats are discarded.
  - An accepted beat with `last` goes to IDLE and sets `ptr <= sel`.
- The FIFO is never written when `i_wr_ready` is low. The FIFO-full condition stalls the granted source only.
- A deasserted `i_req_valid[sel]` mid-packet simply stalls; the grant is held.
- Reset values:
  - state IDLE, `ptr = N_REQ-1` (so source 0 wins first), `cnt = 0`.
  - `o_busy`, `o_grant_id`, `o_trunc`, `o_wr_en` and all `o_req_ready` are 0.
- Reset mid-packet:
  - The arbiter returns to IDLE on the next edge and the partial packet stays in the FIFO.
  - Downstream resynchronises on the next header, or on FIFO reset.

## Timing
- Arbitration takes 1 cycle. The first beat (header or payload) can be written the cycle after the request is seen in IDLE.
- There is a minimum of 1 dead cycle (IDLE) between consecutive packets.
- The data path is combinational from source to FIFO: zero latency, no buffering.
- `o_req_ready`, `o_wr_en` and `o_wr_data` are combinational from the state and `i_wr_ready`.
- `o_busy`, `o_grant_id` and `o_trunc` are registered.
- A single-beat packet (valid and last in the first XFER cycle) is legal and returns to IDLE after that beat.
- A `last` on beat `MAX_BEATS` is not truncation: it returns to IDLE and `o_trunc` stays 0.

## Configuration
- `SAKEBI_ARB_SRCID_EN`: when defined, every packet is preceded by one HDR beat carrying the source index.
- When undefined, the HDR state is not built and IDLE goes directly to XFER.

## Structure
- Package `sakebi_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE/HDR/XFER/DROP);
  - the `ID_W` helper function `$clog2(N_REQ)`;
  - the state encoding constants.
- Sub-module `sakebi_rr_pick` is a combinational round-robin picker. Inputs: `req[N_REQ]` and `ptr`. Outputs: `gnt_id` and `any`. Instantiate it once.

## Test plan
- After reset, sources 0 and 2 both present 3-beat packets (0x10–0x12 and 0x20–0x22):
  - FIFO receives 0x10, 0x11, 0x12, then 0x20, 0x21, 0x22;
  - `o_grant_id` reads 0 then 2;
  - with SRCID_EN, the headers 0x00 and 0x02 precede each packet.
- All 4 sources request continuously with 1-beat packets: grant order 0, 1, 2, 3, 0, 1, and each grant is followed by 1 dead cycle.
- `i_wr_ready` is low for 5 cycles during a packet from source 1:
  - `o_wr_en = 0` and `o_req_ready = 0` throughout;
  - no beat is lost or duplicated;
  - the grant stays 1.
- `MAX_BEATS = 4`, source 3 sends 6 beats with `last` on beat 6:
  - FIFO gets beats 1–4;
  - `o_trunc` pulses once, after beat 4;
  - beats 5–6 are consumed and dropped, then the FSM returns to IDLE.
- `i_rst` is asserted for 1 cycle mid-packet (beat 2 of 5):
  - next cycle all outputs are at their reset values;
  - source 0 wins the next arbitration.
